redis_cache_ctrl_fsm: RTL and testbench
=======================================

Name: redis_cache_ctrl_fsm

Overview:
Cache controller sitting directly downstream of the OBI register interface. It consumes the interface's register snapshot (operation, key, data) and launches one GET/PUT/DEL transaction on the key-value storage port. It runs a req/gnt/rvalid handshake with a watchdog timeout, then writes busy, hit, data and operation=NOP back to the register interface.

Parameters:
KeyWidth, if_types_pkg::RegKeyWidth, key bits carried to storage
DataWidth, if_types_pkg::RegDataWidth, value bits carried to/from storage
TimeoutCycles, 64, max cycles from ISSUE entry to storage response before abort (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
reg_read_i  in  reg_read_t  {dat, key, operation} snapshot from the register interface
reg_write_o  out  reg_write_t  {data_valid, dat, busy_valid, busy, hit_valid, hit, operation_valid, operation} to the register interface
mem_req_o  out  1  storage request
mem_op_o  out  3  latched operation_e (GET/PUT/DEL)
mem_key_o  out  KeyWidth  latched key
mem_wdata_o  out  DataWidth  latched data (PUT only, else 0)
mem_gnt_i  in  1  storage accepted the request
mem_rvalid_i  in  1  storage response valid
mem_hit_i  in  1  key found (GET/DEL) / stored (PUT), qualified by mem_rvalid_i
mem_rdata_i  in  DataWidth  GET value, qualified by mem_rvalid_i
timeout_o  out  1  one-cycle pulse when a transaction aborts on timeout

Behaviour:
- operation_e in ctrl_types_pkg: NOP=0, GET=1, PUT=2, DEL=3; 4..7 are illegal.
- Synchronous reset (rst_n low at posedge) forces: state IDLE, counter 0, all latches 0, mem_req_o=0, timeout_o=0, all reg_write_o fields 0. Reset mid-transaction abandons it with no writeback.
- reg_write_o and mem_* are driven from state and registered latches. All *_valid fields are 0 unless stated.
- IDLE: if operation is GET/PUT/DEL, latch op/key/dat and drive busy_valid=1,busy=1,hit_valid=1,hit=0, then go to ISSUE. If operation is 4..7, drive operation_valid=1,operation=NOP,hit_valid=1,hit=0 and stay IDLE. If NOP, stay IDLE.
- ISSUE: mem_req_o=1 with op/key/wdata held stable until mem_gnt_i. On gnt go to WAIT_RSP. If gnt and rvalid arrive together, capture the response and go straight to DONE.
- WAIT_RSP: mem_req_o=0. On mem_rvalid_i, capture hit and rdata, then go to DONE.
- Counter clears on IDLE->ISSUE and increments every cycle in ISSUE/WAIT_RSP. When it reaches TimeoutCycles-1 with no rvalid: timeout_o=1 for that cycle, captured hit=0, go to DONE. A response arriving in that same cycle wins; no timeout.
- DONE (exactly 1 cycle):
  - busy_valid=1,busy=0; hit_valid=1,hit=captured; operation_valid=1,operation=NOP.
  - data_valid=1,dat=captured rdata only for GET with hit=1.
  - Then go to IDLE.
- No retrigger: the register interface updates at the DONE edge, so IDLE sees NOP the following cycle.
- Latency with gnt and rvalid both immediate: op visible in IDLE at cycle 0, ISSUE at cycle 1, DONE at cycle 2, busy low from cycle 3.
- An OBI write to CTR during ISSUE/WAIT_RSP is ignored by this block. In the register interface an OBI write overrides the controller writeback in the same cycle. That operation is serviced on the next IDLE entry.
- Late storage rvalid/gnt arriving in IDLE/DONE are ignored.

Decomposition:
- ctrl_types_pkg: operation_e, ctrl_state_e {IDLE, ISSUE, WAIT_RSP, DONE}.
- if_types_pkg: reg_read_t, reg_write_t, RegKeyWidth, RegDataWidth.
- Sub-module ctrl_timeout_cnt: clear/enable/expire counter with $clog2(TimeoutCycles) width, sync active-low reset. FSM, latches and writeback stay in the top.

Test Plan:
- Reset then operation=NOP for 20 cycles -> state IDLE, mem_req_o=0, all reg_write_o valids 0 every cycle.
- GET key=0x2A, gnt same cycle, rvalid 3 cycles later with hit=1, rdata=0xDEADBEEF -> busy=1 writeback in cycle 0. DONE drives data_valid=1, dat=0xDEADBEEF, hit=1, busy=0, operation=NOP. Total 6 cycles.
- PUT key=0x5, dat=0x1234, gnt held low 4 cycles -> mem_req_o high with stable key/wdata for 5 cycles. On rvalid hit=1: data_valid=0, hit=1.
- GET with storage silent, TimeoutCycles=8 -> timeout_o pulses exactly once, 7 cycles after ISSUE entry. DONE: hit=0, data_valid=0, operation=NOP. A later stray rvalid is ignored.
- operation=5 -> single cycle operation_valid=1, operation=NOP, hit=0. mem_req_o never asserted.
- GET in WAIT_RSP, rst_n low 1 cycle -> next cycle IDLE, all outputs 0. Subsequent DEL completes normally.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_types_pkg
// Shared controller types: the storage operation encoding carried in the
// register snapshot and the controller state encoding.
// -----------------------------------------------------------------------------
package ctrl_types_pkg;

    // Operation encoding; 3'd4..3'd7 are illegal and never reach storage.
    typedef enum logic [2:0] {
        NOP = 3'd0,
        GET = 3'd1,
        PUT = 3'd2,
        DEL = 3'd3
    } operation_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } ctrl_state_e;

    // True for operations that launch a storage transaction.
    function automatic logic is_txn_op(input logic [2:0] op);
        logic res_s;
        case (op)
            GET, PUT, DEL: res_s = 1'b1;
            default:       res_s = 1'b0;
        endcase
        return res_s;
    endfunction

endpackage : ctrl_types_pkg

// File: rtl/if_types_pkg.sv
// -----------------------------------------------------------------------------
// if_types_pkg
// Register-interface snapshot/writeback structures exchanged between the OBI
// register block and the cache controller.
// -----------------------------------------------------------------------------
package if_types_pkg;

    import ctrl_types_pkg::*;

    localparam int RegKeyWidth  = 16;
    localparam int RegDataWidth = 32;

    // Raw operation field: it may hold an illegal encoding written by software.
    typedef struct packed {
        logic [RegDataWidth-1:0] dat;
        logic [RegKeyWidth-1:0]  key;
        logic [2:0]              operation;
    } reg_read_t;

    typedef struct packed {
        logic                    data_valid;
        logic [RegDataWidth-1:0] dat;
        logic                    busy_valid;
        logic                    busy;
        logic                    hit_valid;
        logic                    hit;
        logic                    operation_valid;
        operation_e              operation;
    } reg_write_t;

endpackage : if_types_pkg

// File: rtl/ctrl_timeout_cnt.sv
// -----------------------------------------------------------------------------
// ctrl_timeout_cnt
// Watchdog counter for one storage transaction.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   clear   : restart from zero (has priority over enable)
//   enable  : count one cycle
//   expired : count has reached TimeoutCycles-1
// -----------------------------------------------------------------------------
module ctrl_timeout_cnt #(
    parameter int TimeoutCycles = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_r;
    logic                at_last_s;

    // Terminal-count decode.
    always_comb begin
        at_last_s = (cnt_r == LastCnt);
    end

    // Counter register; holds at the terminal count so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CntWidth{1'b0}};
        end else if (clear) begin
            cnt_r <= {CntWidth{1'b0}};
        end else if (enable && !at_last_s) begin
            cnt_r <= cnt_r + CntWidth'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry flag.
    always_comb begin
        expired = at_last_s;
    end

endmodule : ctrl_timeout_cnt

// File: rtl/redis_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// redis_cache_ctrl_fsm
// Cache controller: takes the register snapshot, runs one GET/PUT/DEL on the
// key-value storage port (req/gnt/rvalid with watchdog) and writes busy, hit,
// data and operation=NOP back to the register interface.
//   clk, rst_n    : clock, synchronous active-low reset
//   reg_read_i    : {dat, key, operation} snapshot from the register block
//   reg_write_o   : writeback fields with per-field valids
//   mem_req_o     : storage request (held until mem_gnt_i)
//   mem_op_o      : latched operation
//   mem_key_o     : latched key
//   mem_wdata_o   : latched data for PUT, zero otherwise
//   mem_gnt_i     : storage accepted the request
//   mem_rvalid_i  : storage response valid
//   mem_hit_i     : key found / stored, qualified by mem_rvalid_i
//   mem_rdata_i   : GET value, qualified by mem_rvalid_i
//   timeout_o     : one-cycle pulse when a transaction aborts on timeout
// -----------------------------------------------------------------------------
module redis_cache_ctrl_fsm
    import ctrl_types_pkg::*;
    import if_types_pkg::*;
#(
    parameter int KeyWidth      = RegKeyWidth,
    parameter int DataWidth     = RegDataWidth,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  reg_read_t            reg_read_i,
    output reg_write_t           reg_write_o,
    output logic                 mem_req_o,
    output logic [2:0]           mem_op_o,
    output logic [KeyWidth-1:0]  mem_key_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic                 mem_hit_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 timeout_o
);

    ctrl_state_e            state_r;
    ctrl_state_e            state_nxt_s;
    operation_e             op_r;
    logic [KeyWidth-1:0]    key_r;
    logic [DataWidth-1:0]   dat_r;
    logic                   hit_r;
    logic [DataWidth-1:0]   rdata_r;

    logic                   start_s;
    logic                   rsp_s;
    logic                   expired_s;
    logic                   abort_s;
    logic                   cnt_clear_s;
    logic                   cnt_en_s;

    // Transaction-level event decode shared by the FSM, latches and outputs.
    always_comb begin
        start_s = (state_r == IDLE) && is_txn_op(reg_read_i.operation);
        // A response only counts in ISSUE when it arrives together with gnt.
        if (state_r == ISSUE) begin
            rsp_s = mem_gnt_i && mem_rvalid_i;
        end else if (state_r == WAIT_RSP) begin
            rsp_s = mem_rvalid_i;
        end else begin
            rsp_s = 1'b0;
        end
        // A response on the last counted cycle wins over the timeout.
        abort_s     = ((state_r == ISSUE) || (state_r == WAIT_RSP)) && expired_s && !rsp_s;
        cnt_clear_s = start_s;
        cnt_en_s    = (state_r == ISSUE) || (state_r == WAIT_RSP);
    end

    ctrl_timeout_cnt #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear_s),
        .enable (cnt_en_s),
        .expired(expired_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (rsp_s || abort_s) begin
                    state_nxt_s = DONE;
                end else if (mem_gnt_i) begin
                    state_nxt_s = WAIT_RSP;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT_RSP: begin
                if (rsp_s || abort_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Request latches and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r    <= NOP;
            key_r   <= {KeyWidth{1'b0}};
            dat_r   <= {DataWidth{1'b0}};
            hit_r   <= 1'b0;
            rdata_r <= {DataWidth{1'b0}};
        end else if (start_s) begin
            op_r    <= operation_e'(reg_read_i.operation);
            key_r   <= KeyWidth'(reg_read_i.key);
            dat_r   <= DataWidth'(reg_read_i.dat);
            hit_r   <= 1'b0;
            rdata_r <= {DataWidth{1'b0}};
        end else if (rsp_s) begin
            hit_r   <= mem_hit_i;
            rdata_r <= mem_rdata_i;
        end else if (abort_s) begin
            hit_r   <= 1'b0;
            rdata_r <= {DataWidth{1'b0}};
        end else begin
            hit_r   <= hit_r;
            rdata_r <= rdata_r;
        end
    end

    // Writeback and storage-port outputs from state and latches.
    always_comb begin
        reg_write_o = '0;
        mem_req_o   = 1'b0;
        mem_op_o    = op_r;
        mem_key_o   = key_r;
        timeout_o   = abort_s;
        if (op_r == PUT) begin
            mem_wdata_o = dat_r;
        end else begin
            mem_wdata_o = {DataWidth{1'b0}};
        end
        case (state_r)
            IDLE: begin
                if (is_txn_op(reg_read_i.operation)) begin
                    reg_write_o.busy_valid = 1'b1;
                    reg_write_o.busy       = 1'b1;
                    reg_write_o.hit_valid  = 1'b1;
                    reg_write_o.hit        = 1'b0;
                end else if (reg_read_i.operation != 3'(NOP)) begin
                    // Illegal opcode: clear it back to NOP and report a miss.
                    reg_write_o.operation_valid = 1'b1;
                    reg_write_o.operation       = NOP;
                    reg_write_o.hit_valid       = 1'b1;
                    reg_write_o.hit             = 1'b0;
                end else begin
                    reg_write_o = '0;
                end
            end
            ISSUE: begin
                mem_req_o = 1'b1;
            end
            WAIT_RSP: begin
                mem_req_o = 1'b0;
            end
            DONE: begin
                reg_write_o.busy_valid      = 1'b1;
                reg_write_o.busy            = 1'b0;
                reg_write_o.hit_valid       = 1'b1;
                reg_write_o.hit             = hit_r;
                reg_write_o.operation_valid = 1'b1;
                reg_write_o.operation       = NOP;
                if ((op_r == GET) && hit_r) begin
                    reg_write_o.data_valid = 1'b1;
                    reg_write_o.dat        = RegDataWidth'(rdata_r);
                end else begin
                    reg_write_o.data_valid = 1'b0;
                end
            end
            default: begin
                reg_write_o = '0;
            end
        endcase
    end

endmodule : redis_cache_ctrl_fsm

// File: tb/tb_redis_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_redis_cache_ctrl_fsm
// Self-checking bench: a scripted storage responder, a scoreboard of expected
// DONE writebacks, and directed reset / illegal-op / timeout scenarios.
// -----------------------------------------------------------------------------
module tb_redis_cache_ctrl_fsm;

    import ctrl_types_pkg::*;
    import if_types_pkg::*;

    localparam int TO = 8;
    localparam int KW = RegKeyWidth;
    localparam int DW = RegDataWidth;

    logic          clk = 1'b0;
    logic          rst_n;
    reg_read_t     reg_read_s;
    reg_write_t    reg_write_s;
    logic          mem_req_s;
    logic [2:0]    mem_op_s;
    logic [KW-1:0] mem_key_s;
    logic [DW-1:0] mem_wdata_s;
    logic          mem_gnt_s;
    logic          mem_rvalid_s;
    logic          mem_hit_s;
    logic [DW-1:0] mem_rdata_s;
    logic          timeout_s;

    typedef struct {
        logic          data_valid;
        logic [DW-1:0] dat;
        logic          hit;
    } exp_done_t;

    exp_done_t exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    redis_cache_ctrl_fsm #(
        .KeyWidth(KW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_read_i  (reg_read_s),
        .reg_write_o (reg_write_s),
        .mem_req_o   (mem_req_s),
        .mem_op_o    (mem_op_s),
        .mem_key_o   (mem_key_s),
        .mem_wdata_o (mem_wdata_s),
        .mem_gnt_i   (mem_gnt_s),
        .mem_rvalid_i(mem_rvalid_s),
        .mem_hit_i   (mem_hit_s),
        .mem_rdata_i (mem_rdata_s),
        .timeout_o   (timeout_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Idle-quiet check: no writeback, no request, no timeout.
    task automatic check_quiet(input string tag);
        check_eq({tag, "_wb"}, 64'(reg_write_s), 64'd0);
        check_eq({tag, "_req"}, 64'(mem_req_s), 64'd0);
        check_eq({tag, "_to"}, 64'(timeout_s), 64'd0);
    endtask

    // Storage response lines; hit/rdata are deliberately wrong when not valid.
    task automatic drive_mem(input logic gnt, input logic rv, input logic hit, input logic [DW-1:0] rd);
        mem_gnt_s    = gnt;
        mem_rvalid_s = rv;
        mem_hit_s    = rv ? hit : ~hit;
        mem_rdata_s  = rv ? rd : 32'h0BAD_0BAD;
    endtask

    // One transaction; rsp_dly < 0 means storage stays silent.
    task automatic do_txn(input logic [2:0] op, input logic [KW-1:0] key, input logic [DW-1:0] dat,
                          input int gnt_dly, input int rsp_dly, input logic rsp_hit,
                          input logic [DW-1:0] rsp_data);
        int gnt_cyc, rsp_cyc, done_cyc, exp_req, req_cnt, to_cnt, to_cyc;
        bit timed_out, seen_done;
        exp_done_t e, g;
        reg_write_t w;
        gnt_cyc   = 1 + gnt_dly;
        rsp_cyc   = gnt_cyc + rsp_dly;
        timed_out = (rsp_dly < 0) || (rsp_cyc > TO);
        done_cyc  = timed_out ? TO + 1 : rsp_cyc + 1;
        exp_req   = (gnt_cyc < done_cyc) ? gnt_cyc : done_cyc - 1;
        e.hit        = timed_out ? 1'b0 : rsp_hit;
        e.data_valid = (op == 3'(GET)) && e.hit;
        e.dat        = e.data_valid ? rsp_data : 32'h0;

        @(posedge clk); #1;
        reg_read_s.operation = op;
        reg_read_s.key       = key;
        reg_read_s.dat       = dat;
        drive_mem(1'b0, 1'b0, rsp_hit, rsp_data);
        exp_q.push_back(e);
        #1;
        w = '0;
        w.busy_valid = 1'b1;
        w.busy       = 1'b1;
        w.hit_valid  = 1'b1;
        check_eq("idle_wb", 64'(reg_write_s), 64'(w));

        seen_done = 0; req_cnt = 0; to_cnt = 0; to_cyc = -1;
        for (int cyc = 1; (cyc <= done_cyc + 3) && !seen_done; cyc++) begin
            @(posedge clk); #1;
            drive_mem(cyc == gnt_cyc, (rsp_dly >= 0) && (cyc == rsp_cyc), rsp_hit, rsp_data);
            #1;
            if (timeout_s) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (mem_req_s) begin
                req_cnt++;
                check_eq("mem_op", 64'(mem_op_s), 64'(op));
                check_eq("mem_key", 64'(mem_key_s), 64'(key));
                check_eq("mem_wdata", 64'(mem_wdata_s), (op == 3'(PUT)) ? 64'(dat) : 64'd0);
            end
            if (reg_write_s.busy_valid && !reg_write_s.busy) begin
                seen_done = 1;
                check_eq("done_cycle", 64'(cyc), 64'(done_cyc));
                check_eq("sb_size", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    g = exp_q.pop_front();
                    w = '0;
                    w.busy_valid      = 1'b1;
                    w.hit_valid       = 1'b1;
                    w.hit             = g.hit;
                    w.operation_valid = 1'b1;
                    w.operation       = NOP;
                    w.data_valid      = g.data_valid;
                    w.dat             = g.dat;
                    check_eq("done_wb", 64'(reg_write_s), 64'(w));
                end
                // Register block clears the opcode at the DONE edge.
                reg_read_s.operation = 3'(NOP);
            end else begin
                check_eq("busy_wb", 64'(reg_write_s), 64'd0);
            end
        end
        drive_mem(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("done_seen", 64'(seen_done), 64'd1);
        check_eq("req_cycles", 64'(req_cnt), 64'(exp_req));
        check_eq("timeout_pulses", 64'(to_cnt), timed_out ? 64'd1 : 64'd0);
        if (timed_out) begin
            check_eq("timeout_cycle", 64'(to_cyc), 64'(TO));
        end
        @(posedge clk); #2;
        check_quiet("post_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_write_t w;
        int to_cnt;
        rst_n = 1'b0;
        reg_read_s = '0;
        drive_mem(1'b0, 1'b0, 1'b0, 32'h0);
        // Reset, then NOP for 20 cycles.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_eq("rst_key", 64'(mem_key_s), 64'd0);
        check_eq("rst_wdata", 64'(mem_wdata_s), 64'd0);
        check_eq("rst_op", 64'(mem_op_s), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            check_quiet("nop_idle");
        end

        // GET, gnt immediate, rvalid 3 cycles later.
        do_txn(3'(GET), 16'h002A, 32'h0, 0, 3, 1'b1, 32'hDEAD_BEEF);
        // PUT with gnt held off 4 cycles.
        do_txn(3'(PUT), 16'h0005, 32'h0000_1234, 4, 2, 1'b1, 32'h5555_AAAA);
        // Silent storage: timeout.
        do_txn(3'(GET), 16'h0011, 32'h0, 0, -1, 1'b1, 32'h1111_2222);
        // Stray late response in IDLE.
        @(posedge clk); #1;
        drive_mem(1'b1, 1'b1, 1'b1, 32'hFFFF_0000);
        #1;
        check_quiet("stray");
        @(posedge clk); #1;
        drive_mem(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check_quiet("stray_after");
        end

        // Illegal opcode 5.
        @(posedge clk); #1;
        reg_read_s.operation = 3'd5;
        #1;
        w = '0;
        w.operation_valid = 1'b1;
        w.operation       = NOP;
        w.hit_valid       = 1'b1;
        check_eq("illegal_wb", 64'(reg_write_s), 64'(w));
        check_eq("illegal_req", 64'(mem_req_s), 64'd0);
        @(posedge clk); #1;
        reg_read_s.operation = 3'(NOP);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check_quiet("illegal_after");
        end

        // Reset in WAIT_RSP.
        @(posedge clk); #1;
        reg_read_s.operation = 3'(GET);
        reg_read_s.key       = 16'h0077;
        @(posedge clk); #1;
        drive_mem(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive_mem(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("wait_req", 64'(mem_req_s), 64'd0);
        reg_read_s.operation = 3'(NOP);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_quiet("midrst");
        check_eq("midrst_key", 64'(mem_key_s), 64'd0);
        check_eq("midrst_op", 64'(mem_op_s), 64'd0);
        to_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            if (timeout_s || mem_req_s || (reg_write_s != '0)) to_cnt++;
        end
        check_eq("midrst_silent", 64'(to_cnt), 64'd0);
        do_txn(3'(DEL), 16'h0077, 32'h0, 1, 1, 1'b1, 32'h0);

        // Both handshakes immediate, response on the last counted cycle,
        // a miss, and a request never granted.
        do_txn(3'(GET), 16'h0100, 32'h0, 0, 0, 1'b1, 32'hCAFE_F00D);
        do_txn(3'(GET), 16'h0200, 32'h0, 0, TO - 1, 1'b1, 32'h0BEE_F123);
        do_txn(3'(GET), 16'h0300, 32'h0, 2, 1, 1'b0, 32'h7777_7777);
        do_txn(3'(PUT), 16'h0400, 32'hABCD_0001, 20, -1, 1'b1, 32'h0);

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_redis_cache_ctrl_fsm
